// File: rtl/instr_encoder_pkg.sv
// Shared MIPS ISA definitions: opcodes, encoder class codes and the class decode helper.
// The control unit uses the same opcode constants, so edit them with care.
package mips_isa_defs;

    localparam int unsigned OpSelW = 4;

    localparam logic [5:0] OpcRtype = 6'b000000;
    localparam logic [5:0] OpcLw    = 6'b100011;
    localparam logic [5:0] OpcLwc1  = 6'b110001;
    localparam logic [5:0] OpcSw    = 6'b101011;
    localparam logic [5:0] OpcBeq   = 6'b000100;
    localparam logic [5:0] OpcAddi  = 6'b001000;
    localparam logic [5:0] OpcSlti  = 6'b001010;
    localparam logic [5:0] OpcAndi  = 6'b001100;
    localparam logic [5:0] OpcOri   = 6'b001101;

    typedef enum logic [OpSelW-1:0] {
        OpR    = 4'd0,
        OpLw   = 4'd1,
        OpLwc1 = 4'd2,
        OpSw   = 4'd3,
        OpBeq  = 4'd4,
        OpAddi = 4'd5,
        OpSlti = 4'd6,
        OpAndi = 4'd7,
        OpOri  = 4'd8
    } op_class_e;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } enc_state_e;

    typedef struct packed {
        logic [5:0] opcode;
        logic       legal;
        logic       is_rtype;
    } op_info_t;

    function automatic op_info_t decode_class(input logic [OpSelW-1:0] op_sel);
        op_info_t info;
        info = '{opcode: OpcRtype, legal: 1'b1, is_rtype: 1'b0};
        case (op_sel)
            OpR:    info.is_rtype = 1'b1;
            OpLw:   info.opcode = OpcLw;
            OpLwc1: info.opcode = OpcLwc1;
            OpSw:   info.opcode = OpcSw;
            OpBeq:  info.opcode = OpcBeq;
            OpAddi: info.opcode = OpcAddi;
            OpSlti: info.opcode = OpcSlti;
            OpAndi: info.opcode = OpcAndi;
            OpOri:  info.opcode = OpcOri;
            default: info.legal = 1'b0;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// Combinational packer: turns an instruction class and its fields into a 32-bit MIPS word.
module instr_field_pack
    import mips_isa_defs::*;
(
    input  logic [OpSelW-1:0] i_op_sel,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [5:0]        i_funct,
    input  logic [15:0]       i_imm,
    output logic [31:0]       o_word,
    output logic              o_legal
);

    op_info_t w_info;

    always_comb begin
        w_info  = decode_class(i_op_sel);
        o_legal = w_info.legal;
        o_word  = '0;
        if (w_info.legal) begin
            if (w_info.is_rtype) begin
                o_word = {OpcRtype, i_rs, i_rt, i_rd, i_shamt, i_funct};
            end else begin
                // I-type: rd/shamt/funct are don't-care, imm passes through untouched
                o_word = {w_info.opcode, i_rs, i_rt, i_imm};
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts descriptors, packs them and emits word + sequential address
// through a single output holding register.
module instr_encoder
    import mips_isa_defs::*;
#(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_base_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_op_sel,
    input  logic [4:0]        i_rs,
    input  logic [4:0]        i_rt,
    input  logic [4:0]        i_rd,
    input  logic [4:0]        i_shamt,
    input  logic [5:0]        i_funct,
    input  logic [15:0]       i_imm,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_out_instr,
    output logic [ADDR_W-1:0] o_out_addr,
    output logic              o_err,
    output logic [15:0]       o_count
);

    enc_state_e        r_state;
    enc_state_e        w_state_next;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic              r_err;
    logic [15:0]       r_count;

    logic [31:0]       w_word;
    logic              w_legal;
    logic              w_accept;
    logic              w_load;
    logic              w_consume;

    instr_field_pack u_pack (
        .i_op_sel (i_op_sel),
        .i_rs     (i_rs),
        .i_rt     (i_rt),
        .i_rd     (i_rd),
        .i_shamt  (i_shamt),
        .i_funct  (i_funct),
        .i_imm    (i_imm),
        .o_word   (w_word),
        .o_legal  (w_legal)
    );

    assign o_in_ready  = (r_state == StEmpty) || i_out_ready;
    assign o_out_valid = (r_state == StFull);
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_load      = w_accept && w_legal;
    assign w_consume   = o_out_valid && i_out_ready;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StEmpty: if (w_load) w_state_next = StFull;
            StFull: begin
                // Illegal accept while draining still empties the register
                if (w_load) begin
                    w_state_next = StFull;
                end else if (w_consume) begin
                    w_state_next = StEmpty;
                end
            end
            default: w_state_next = StEmpty;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StEmpty;
            r_instr <= '0;
            r_addr  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_err   <= w_accept && !w_legal;
            if (w_load) begin
                r_instr <= w_word;
                r_addr  <= r_addr_cnt;
            end
        end
    end

    // base_load only lands on an idle, non-accepting cycle; otherwise it is dropped
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr_cnt <= '0;
        end else if (w_load) begin
            r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
        end else if ((r_state == StEmpty) && !w_accept && i_base_load) begin
            r_addr_cnt <= i_base_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_consume && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_out_instr = r_instr;
    assign o_out_addr  = r_addr;
    assign o_err       = r_err;
    assign o_count     = r_count;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and program writer: the inverse of the opcode decoder in the control unit. It accepts symbolic instruction descriptors (class plus register and immediate fields) over a valid/ready handshake and packs each one into a 32-bit MIPS word. It emits each word with a sequential instruction-memory word address, so test programs and boot images can be streamed into instruction memory. It covers the same instruction set the control unit decodes: R-type, LW, LWC1, SW, BEQ, ADDI, SLTI, ANDI and ORI.

## Interface
- ADDR_W, 8: width of the output word address; the address wraps modulo 2^ADDR_W.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- base_load  in  1  loads base_addr into the address counter. Honoured only when no output is pending.
- base_addr  in  ADDR_W  start word address for base_load.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  descriptor accepted when in_valid && in_ready.
- op_sel  in  4  instruction class: 0 R, 1 LW, 2 LWC1, 3 SW, 4 BEQ, 5 ADDI, 6 SLTI, 7 ANDI, 8 ORI; 9-15 are illegal.
- rs, rt, rd, shamt  in  5 each  register and shift fields.
- funct  in  6  R-type function field.
- imm  in  16  immediate or branch offset, passed through unmodified.
- out_valid  out  1  a packed word is pending.
- out_ready  in  1  the downstream writer consumes the word when out_valid && out_ready.
- out_instr  out  32  packed instruction word.
- out_addr  out  ADDR_W  word address for out_instr.
- err  out  1  one-cycle pulse when an illegal op_sel is accepted.
- count  out  16  number of words emitted since reset; saturates at 0xFFFF.

## Operation
- FSM states: EMPTY and FULL (one output holding register).
- in_ready = (state == EMPTY) || out_ready. This gives full throughput with no bubble.
- Accepting a legal descriptor loads out_instr and out_addr and moves to FULL (or stays in FULL).
- Packing:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - All other classes: {opcode, rs, rt, imm}; rd, shamt and funct are ignored.
- Opcodes: LW 100011, LWC1 110001, SW 101011, BEQ 000100, ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101.
- Illegal op_sel:
  - The descriptor is still accepted (in_ready behaves normally), so a bad descriptor never stalls upstream.
  - No word is emitted and the address does not advance.
  - err = 1 in the next cycle.
  - If the output is FULL and out_ready fires in the same cycle, the FSM goes FULL→EMPTY.
- Address counter:
  - Holds the address of the next word.
  - Captured into out_addr on accept; increments by 1 on each legal accept.
  - Wraps from 2^ADDR_W−1 to 0 silently.
- count increments on each output handshake (out_valid && out_ready) and saturates at 0xFFFF.
- base_load:
  - Applied when state == EMPTY and no accept occurs that cycle.
  - Otherwise ignored; it is not queued.
- Simultaneous consume and legal accept in FULL: the register is replaced with the new word and the state stays FULL.

## Timing
- Reset values: state EMPTY, out_valid 0, out_instr 0, out_addr 0, address counter 0, err 0, count 0. in_ready = 1 in the cycle after reset.
- Reset asserted mid-operation discards the pending word immediately at the next edge.
- Latency: a descriptor accepted at edge N appears with out_valid = 1 after edge N (one cycle).
- out_instr and out_addr hold stable while out_valid && !out_ready.
- err is registered and lasts exactly one cycle per illegal accept.
- Back-to-back illegal accepts produce consecutive err cycles.
- Sustained throughput is one word per cycle while out_ready = 1.

## Structure
- The shared package (mips_isa_defs) holds:
  - the opcode constants listed above, which the control unit also uses;
  - the op_sel class codes;
  - the R-type opcode 6'b000000.
- Sub-module instr_field_pack: purely combinational. Inputs are op_sel plus the instruction fields; outputs are word[31:0] and legal.
- The top level contains only the FSM, the holding register, the address counter and the count counter.

## Test plan
- R add: op_sel 0, rs 1, rt 2, rd 3, shamt 0, funct 100000, base 0 → out_instr 0x00221820, out_addr 0 one cycle later.
- LW then BEQ back-to-back with out_ready = 1:
  - LW rs 9, rt 8, imm 4 → 0x8D280004 @ addr 0.
  - BEQ rs 1, rt 2, imm 0xFFFF → 0x1022FFFF @ addr 1.
  - No bubble between them.
- Backpressure: ADDI rs 0, rt 1, imm 5 → 0x20010005.
  - Hold out_ready = 0 for 3 cycles: out_instr and out_addr are stable and in_ready = 0.
  - Release out_ready: count becomes 1.
- Illegal op_sel 12 between two ORIs:
  - err pulses for one cycle.
  - The ORIs land at consecutive addresses 0 and 1.
  - count ends at 2.
- Wrap: ADDR_W = 8, base_load 255, two SW descriptors → out_addr 255 then 0.
- Reset mid-FULL: assert rst while out_valid = 1 → next cycle out_valid 0, count 0, out_addr 0.
